// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: synchronises rx, times each bit from the start-bit edge,
// strobes every data bit out, assembles the character and flags bad stop bits.
module uart_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rx,
  output logic                 bit_valid,
  output logic                 bit_out,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           fsm_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;

  // bit_valid, byte_valid and frame_err are single-cycle strobes with no
  // back-pressure: the consumer must take them in the cycle they are high.
  // bit_out and byte_out hold their last strobed value between strobes.

  // LSB-first: each new bit enters at the top and the register shifts right.
  always_comb begin
    shreg_next                = shreg >> 1;
    shreg_next[DATA_BITS-1]   = rx_s;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            bit_out   <= rx_s;
            bit_valid <= 1'b1;
            shreg     <= shreg_next;
            if (idx == IDX_LAST) begin
              state <= S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          // Leaving mid-stop-bit lets a start bit with no idle gap be caught.
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_out   <= shreg;
              state      <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BRK: begin
          // A line held low after a bad stop bit must not look like a start bit.
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule
